// File: rtl/ula_exec_stage.sv
// rtl/ula_exec_stage.sv - execute stage wrapping an external ULA with an internal serial divider
module ula_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_operand_a,
  output logic [WIDTH-1:0] alu_operand_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic [1:0]       alu_compare,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic [1:0]       out_compare,
  output logic             out_illegal,
  output logic             busy
);

  localparam logic [3:0] OP_DIV       = 4'b0011;
  localparam logic [3:0] OP_FIRST_BAD = 4'b1010;
  localparam logic [4:0] LAST_ITER    = 5'd31;

  typedef enum logic [1:0] {IDLE, EXEC, DIV_RUN, DONE} state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;

  logic             accept;
  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign accept        = in_valid && in_ready;
  assign alu_operand_a = a_q;
  assign alu_operand_b = b_q;
  assign alu_opcode    = op_q;

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and subtract the divisor when it fits. quo_q starts
  // as the dividend and is shifted left, so quotient bits fill in from the LSB.
  always_comb begin
    trial    = {rem_q, quo_q[WIDTH-1]};
    take     = (trial >= {1'b0, b_q});
    rem_next = take ? (trial[WIDTH-1:0] - b_q) : trial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], take};
  end

  // Control FSM with registered handshake/status outputs and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_compare  <= 2'b00;
      out_illegal  <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt          <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= in_opcode;
            a_q      <= in_a;
            b_q      <= in_b;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_opcode == OP_DIV && in_b != '0) begin
              state <= DIV_RUN;
              cnt   <= '0;
              rem_q <= '0;
              quo_q <= in_a;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          // Division only lands here when the divisor is zero.
          if (op_q >= OP_FIRST_BAD) begin
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_compare  <= 2'b00;
            out_illegal  <= 1'b1;
          end else if (op_q == OP_DIV) begin
            out_result   <= '1;
            out_overflow <= 1'b1;
            out_compare  <= 2'b00;
            out_illegal  <= 1'b0;
          end else begin
            out_result   <= alu_result;
            out_overflow <= alu_overflow;
            out_compare  <= alu_compare;
            out_illegal  <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DIV_RUN: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (cnt == LAST_ITER) begin
            out_result   <= quo_next;
            out_overflow <= 1'b0;
            out_compare  <= 2'b00;
            out_illegal  <= 1'b0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ula_exec_stage.md
ULA_EXEC_STAGE -- requirements
Module: ula_exec_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream request present.
REQ-005 in_ready  output  1  stage can accept a request.
REQ-006 in_opcode  input  4  ULA opcode (0000 ADD ... 1001 CMP).
REQ-007 in_a / in_b  input  32 each  operands.
REQ-008 alu_operand_a / alu_operand_b  output  32 each  to ula operand ports.
REQ-009 alu_opcode  output  4  to ula opcode port.
REQ-010 alu_result  input  32; alu_overflow  input  1; alu_compare  input  2  from ula outputs.
REQ-011 out_valid  output  1  result held for downstream.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_result  output  32; out_overflow  output  1; out_compare  output  2; out_illegal  output  1.
REQ-014 busy  output  1  high in any state except IDLE.

Function
REQ-015 States: IDLE, EXEC, DIV_RUN, DONE.
REQ-016 in_ready = 1 only in IDLE; accept = in_valid & in_ready.
REQ-017 On accept, opcode/a/b latched into internal registers; alu_* outputs always driven from these registers.
REQ-018 Accept with opcode != 0011, or 0011 with in_b == 0: IDLE -> EXEC.
REQ-019 Accept with opcode 0011 and in_b != 0: IDLE -> DIV_RUN, iteration counter loaded 0.
REQ-020 EXEC lasts exactly one cycle; at its end edge alu_result/alu_overflow/alu_compare are captured into out_* and state -> DONE.
REQ-021 Opcodes 1010-1111: EXEC captures out_result 0, out_overflow 0, out_compare 00, out_illegal 1; ula outputs ignored.
REQ-022 DIV by zero: EXEC captures out_result 32'hFFFFFFFF, out_overflow 1, out_compare 00, out_illegal 0.
REQ-023 DIV_RUN: internal unsigned restoring divider, one quotient bit per cycle MSB first, exactly 32 cycles; counter 0..31, no wrap.
REQ-024 DIV_RUN end (counter 31): out_result = quotient, out_overflow 0, out_compare 00, out_illegal 0, state -> DONE; remainder discarded.
REQ-025 Accept-to-out_valid latency: 2 edges for non-DIV/div-by-zero; 33 edges for DIV.
REQ-026 out_valid = 1 only in DONE; out_* stable while out_valid & !out_ready.
REQ-027 DONE & out_ready: state -> IDLE next edge; in_ready rises the cycle after result handshake (no same-cycle accept).
REQ-028 in_valid while not IDLE: ignored, no state change; upstream must hold request.
REQ-029 out_illegal = 0 for all opcodes 0000-1001.

Reset
REQ-030 reset sampled high: state IDLE, out_valid 0, out_result 0, out_overflow 0, out_compare 00, out_illegal 0, busy 0, counter 0, latched operands/opcode 0.
REQ-031 reset overrides any state incl. mid-DIV_RUN and DONE; in-flight op discarded, no output produced.
REQ-032 reset and in_valid same cycle: request not accepted.

Verification
REQ-033 ADD 5,10 accepted, out_ready 1 -> out_valid 2 cycles later, out_result 15, overflow 0, illegal 0.
REQ-034 DIV 50,10 -> busy 1 for 33 cycles, out_valid at edge 33, out_result 5, overflow 0; in_ready 0 throughout.
REQ-035 DIV 7,0 -> out_valid at edge 2, out_result 32'hFFFFFFFF, out_overflow 1.
REQ-036 SUB 20,8 with out_ready low 5 cycles, in_valid held high with ADD -> out_result 12 stable, ADD not accepted until cycle after out handshake.
REQ-037 reset at DIV_RUN cycle 10 of DIV 100,3 -> next cycle IDLE, out_valid 0, in_ready 1, no result ever emitted.
REQ-038 Opcode 1100 -> out_illegal 1, out_result 0; CMP 10,20 -> out_compare equals ula compareResult, illegal 0.
